// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART transmit arbiter.
// CKSUM state exists only when UART_TX_ARB_CHECKSUM_EN is defined.
package uart_pkg;

   localparam int CLK_FREQ    = 50_000_000;
   localparam int BAUD_RATE   = 115_200;
   localparam int MAX_LEN_DEF = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_LOAD,
      S_START,
      S_WAIT_LO,
      S_WAIT_HI,
`ifdef UART_TX_ARB_CHECKSUM_EN
      S_CKSUM,
`endif
      S_DONE
   } state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
// Searches from ptr+1 upward (wrapping) for the first active request.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   logic found;

   // first requester after ptr wins
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         if (!found && req[(int'(ptr) + k) % N]) begin
            found = 1'b1;
            gnt[(int'(ptr) + k) % N] = 1'b1;
            idx = IW'((int'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin packet arbiter in front of one UART transmitter.
// Define UART_TX_ARB_CHECKSUM_EN to append an XOR checksum byte per packet.
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int MAX_LEN = MAX_LEN_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   byte_ack,
   output logic [NUM_REQ-1:0]   grant,
   output logic [7:0]           tx_data,
   output logic                 tx_start,
   input  logic                 tx_ready,
   output logic                 busy,
   output logic                 overrun
);

   localparam int IW = $clog2(NUM_REQ);

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q;
   logic [IW-1:0]        ptr_q;
   logic [4:0]           cnt_q;
   logic                 last_q;
   logic [7:0]           tx_data_q;
   logic [NUM_REQ-1:0]   pick_gnt;
   logic [IW-1:0]        pick_idx;
   logic [7:0]           sel_byte;
   logic                 sel_last;
   logic                 at_max;
`ifdef UART_TX_ARB_CHECKSUM_EN
   logic [7:0]           cks_q;
   logic                 ck_sent_q;
`endif

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req (req),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx)
   );

   // ptr always holds the current owner once granted
   assign sel_byte = req_data[8*int'(ptr_q) +: 8];
   assign sel_last = req_last[ptr_q];
   assign at_max   = (cnt_q == 5'(MAX_LEN - 1));

   assign grant   = grant_q;
   assign tx_data = tx_data_q;
   assign busy    = (state_q != S_IDLE);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // next state and strobes
   always_comb begin
      state_d  = state_q;
      tx_start = 1'b0;
      byte_ack = '0;
      overrun  = 1'b0;
      unique case (state_q)
         S_IDLE:    if (|req) state_d = S_ARB;
         S_ARB:     state_d = (|req) ? S_LOAD : S_IDLE;
         S_LOAD: begin
            byte_ack = grant_q;
            overrun  = at_max & ~sel_last;
            state_d  = S_START;
         end
         S_START: begin
            if (tx_ready) begin
               tx_start = 1'b1;
               state_d  = S_WAIT_LO;
            end
         end
         S_WAIT_LO: if (!tx_ready) state_d = S_WAIT_HI;
         S_WAIT_HI: begin
            if (tx_ready) begin
               if (!last_q)        state_d = S_LOAD;
`ifdef UART_TX_ARB_CHECKSUM_EN
               else if (!ck_sent_q) state_d = S_CKSUM;
`endif
               else                state_d = S_DONE;
            end
         end
`ifdef UART_TX_ARB_CHECKSUM_EN
         S_CKSUM:   state_d = S_START;
`endif
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // grant, pointer, byte counter and data path
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q   <= '0;
         ptr_q     <= IW'(NUM_REQ - 1);
         cnt_q     <= '0;
         last_q    <= 1'b0;
         tx_data_q <= 8'h00;
`ifdef UART_TX_ARB_CHECKSUM_EN
         cks_q     <= 8'h00;
         ck_sent_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_ARB: begin
               if (|req) begin
                  grant_q <= pick_gnt;
                  ptr_q   <= pick_idx;
               end
`ifdef UART_TX_ARB_CHECKSUM_EN
               cks_q     <= 8'h00;
               ck_sent_q <= 1'b0;
`endif
            end
            S_LOAD: begin
               tx_data_q <= sel_byte;
               last_q    <= sel_last | at_max;
`ifdef UART_TX_ARB_CHECKSUM_EN
               cks_q     <= cks_q ^ sel_byte;
`endif
            end
            S_WAIT_HI: begin
               if (tx_ready && !last_q) cnt_q <= cnt_q + 5'd1;
            end
`ifdef UART_TX_ARB_CHECKSUM_EN
            S_CKSUM: begin
               tx_data_q <= cks_q;
               ck_sent_q <= 1'b1;
            end
`endif
            S_DONE: begin
               grant_q <= '0;
               cnt_q   <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: randomized bench for uart_tx_arb with a packet-level
// reference model (round-robin over queued packets, truncation, checksum).
module tb_uart_tx_arb;

   localparam int N  = 4;
   localparam int ML = 4;
`ifdef UART_TX_ARB_CHECKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   typedef struct packed {
      logic [2:0] g;
      logic [7:0] d;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [N-1:0]   req = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]   req_last = '0;
   logic [N-1:0]   byte_ack;
   logic [N-1:0]   grant;
   logic [7:0]     tx_data;
   logic           tx_start;
   logic           tx_ready;
   logic           busy;
   logic           overrun;

   logic           tx_rdy_m = 1'b1;
   logic           hold_low = 1'b0;
   assign tx_ready = tx_rdy_m & ~hold_low;

   uart_tx_arb #(
      .NUM_REQ (N),
      .MAX_LEN (ML)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .req_data (req_data),
      .req_last (req_last),
      .byte_ack (byte_ack),
      .grant    (grant),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_ready (tx_ready),
      .busy     (busy),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   logic [7:0] bq    [N][$];
   int         plen  [N][$];
   bit         pterm [N][$];
   int         sent  [N];
   bit         prev_ack [N];
   bit         prev_gnt [N];

   exp_t       exp_q [$];
   logic [3:0] gq [$];
   int n_chk = 0, n_err = 0;
   int exp_acks, exp_ovr, m_ptr;
   int ack_cnt, ovr_cnt, ovr_at, start_cnt;
   logic [3:0] first_gnt;
   logic [7:0] last_tx;
   bit   drop_pend;
   int   lo_cnt;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < N; i++) s += plen[i].size();
      return s;
   endfunction

   task automatic drive_reqs();
      int rem;
      for (int i = 0; i < N; i++) begin
         if (plen[i].size() > 0) begin
            rem = plen[i][0] - sent[i];
            req[i] = 1'b1;
            req_data[8*i +: 8] = (rem > 0) ? bq[i][0] : 8'h00;
            req_last[i] = pterm[i][0] && (rem == 1);
         end else begin
            req[i] = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i] = 1'b0;
         end
      end
   endtask

   task automatic add_pkt(input int r, input int len, input bit term,
                          input logic [31:0] seed);
      for (int b = 0; b < len; b++) begin
         if (b < 4) bq[r].push_back(seed[8*b +: 8]);
         else       bq[r].push_back(8'($urandom()));
      end
      plen[r].push_back(len);
      pterm[r].push_back(term);
   endtask

   task automatic rand_pkt(input int r);
      if ($urandom_range(0, 3) == 0)
         add_pkt(r, ML + $urandom_range(0, 2), 1'b0, $urandom());
      else
         add_pkt(r, $urandom_range(1, 5), 1'b1, $urandom());
   endtask

   // expected byte stream from the queued packets, in round-robin order
   task automatic model_build();
      int k_i [N];
      int off [N];
      int tot, j, len, n;
      bit fnd, term;
      logic [7:0] x, d;
      tot = pending();
      j = 0;
      for (int i = 0; i < N; i++) begin
         k_i[i] = 0;
         off[i] = 0;
      end
      repeat (tot) begin
         fnd = 1'b0;
         for (int k = 1; k <= N; k++) begin
            if (!fnd && k_i[(m_ptr + k) % N] < plen[(m_ptr + k) % N].size()) begin
               fnd = 1'b1;
               j = (m_ptr + k) % N;
            end
         end
         m_ptr = j;
         len  = plen[j][k_i[j]];
         term = pterm[j][k_i[j]];
         n = (term && len <= ML) ? len : ML;
         x = 8'h00;
         for (int b = 0; b < n; b++) begin
            d = bq[j][off[j] + b];
            exp_q.push_back('{g: 3'(j), d: d});
            x = x ^ d;
         end
         if (CK == 1) exp_q.push_back('{g: 3'(j), d: x});
         exp_acks += n;
         if (!(term && len <= ML)) exp_ovr++;
         off[j] += len;
         k_i[j]++;
      end
   endtask

   // requesters: advance after an ack, drop the packet when grant falls
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            prev_ack[i] = 1'b0;
            prev_gnt[i] = 1'b0;
            sent[i] = 0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (prev_ack[i] && bq[i].size() > 0) begin
               void'(bq[i].pop_front());
               sent[i]++;
            end
            if (prev_gnt[i] && !grant[i] && plen[i].size() > 0) begin
               repeat (plen[i][0] - sent[i]) void'(bq[i].pop_front());
               void'(plen[i].pop_front());
               void'(pterm[i].pop_front());
               sent[i] = 0;
            end
            prev_ack[i] = byte_ack[i];
            prev_gnt[i] = grant[i];
         end
         drive_reqs();
      end
   end

   // transmitter model and output scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         drop_pend = 1'b0;
         lo_cnt = 0;
         tx_rdy_m = 1'b1;
      end else begin
         if (drop_pend) begin
            tx_rdy_m = 1'b0;
            lo_cnt = $urandom_range(2, 5);
            drop_pend = 1'b0;
         end else if (lo_cnt > 0) begin
            lo_cnt--;
            if (lo_cnt == 0) tx_rdy_m = 1'b1;
         end
         if (tx_start) begin
            start_cnt++;
            drop_pend = 1'b1;
            if (start_cnt == 1) first_gnt = grant;
            last_tx = tx_data;
            gq.push_back(grant);
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{g: 3'd7, d: 8'h00};
            check("tx_gnt", grant, 32'(1) << e.g);
            check("tx_data", tx_data, e.d);
         end
         if (byte_ack != '0) ack_cnt++;
         if (overrun) begin
            ovr_cnt++;
            ovr_at = ack_cnt;
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_grant", grant, 0);
      check("rst_ack", byte_ack, 0);
      check("rst_start", tx_start, 0);
      check("rst_data", tx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_ovr", overrun, 0);
      for (int i = 0; i < N; i++) begin
         bq[i].delete();
         plen[i].delete();
         pterm[i].delete();
      end
      exp_q.delete();
      gq.delete();
      exp_acks = 0; exp_ovr = 0; m_ptr = N - 1;
      ack_cnt = 0; ovr_cnt = 0; ovr_at = 0; start_cnt = 0;
      first_gnt = '0; last_tx = '0;
      drive_reqs();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic run_wait(input string tag);
      int cyc = 0;
      while (!(pending() == 0 && !busy) && cyc < 3000) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check({tag, "_timeout"}, cyc < 3000, 1);
      check({tag, "_acks"}, ack_cnt, exp_acks);
      check({tag, "_ovr"}, ovr_cnt, exp_ovr);
      check({tag, "_left"}, exp_q.size(), 0);
      check({tag, "_grant"}, grant, 0);
   endtask

   initial begin
      logic [3:0] ord [6];
      int cyc;
      ord = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
      @(posedge clk);
      #1;

      // single packet
      do_reset();
      add_pkt(0, 2, 1'b1, 32'h0000_3CA5);
      model_build();
      drive_reqs();
      run_wait("single");
      check("single_starts", start_cnt, 2 + CK);
      check("single_acks2", ack_cnt, 2);

      // contention, 1-byte packets from 0, 1, 3
      do_reset();
      for (int p = 0; p < 2; p++) begin
         add_pkt(0, 1, 1'b1, $urandom());
         add_pkt(1, 1, 1'b1, $urandom());
         add_pkt(3, 1, 1'b1, $urandom());
      end
      model_build();
      drive_reqs();
      run_wait("cont");
      for (int i = 0; i < 6; i++)
         check("cont_order", gq[i*(1+CK)], ord[i]);

      // truncation at MAX_LEN
      do_reset();
      add_pkt(2, 6, 1'b0, $urandom());
      model_build();
      drive_reqs();
      run_wait("ovr");
      check("ovr_starts", start_cnt, ML + CK);
      check("ovr_count", ovr_cnt, 1);
      check("ovr_at", ovr_at, ML);

      // slow ready after reset
      hold_low = 1'b1;
      do_reset();
      add_pkt(1, 2, 1'b1, $urandom());
      model_build();
      drive_reqs();
      repeat (50) @(posedge clk);
      #1;
      check("slow_nostart", start_cnt, 0);
      check("slow_busy", busy, 1);
      hold_low = 1'b0;
      run_wait("slow");

`ifdef UART_TX_ARB_CHECKSUM_EN
      do_reset();
      add_pkt(1, 3, 1'b1, 32'h0056_3412);
      model_build();
      drive_reqs();
      run_wait("cks");
      check("cks_starts", start_cnt, 4);
      check("cks_byte", last_tx, 8'h70);
      check("cks_acks", ack_cnt, 3);
`endif

      // random rounds, pointer carried across rounds
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 1) == 1)
               repeat ($urandom_range(1, 2)) rand_pkt(i);
         if (pending() == 0) rand_pkt($urandom_range(0, N - 1));
         model_build();
         drive_reqs();
         run_wait("rnd");
      end

      // reset while waiting on byte 2 of a packet from requester 1
      do_reset();
      add_pkt(1, 3, 1'b1, 32'h0033_2211);
      model_build();
      drive_reqs();
      cyc = 0;
      while (start_cnt < 2 && cyc < 500) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("mid_reach", start_cnt, 2);
      @(posedge clk);
      #1;
      check("mid_busy", busy, 1);
      do_reset();
      add_pkt(2, 2, 1'b1, $urandom());
      add_pkt(0, 2, 1'b1, $urandom());
      model_build();
      drive_reqs();
      run_wait("mid");
      check("mid_first", first_gnt, 4'b0001);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter: MAX_LEN, default 16, maximum bytes per packet, excluding the checksum byte.
REQ-003 Port: clk  input  1  system clock; the single clock for all logic.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: req  input  NUM_REQ  per-requester packet request; level-sensitive.
REQ-006 Port: req_data  input  8*NUM_REQ  current byte of each requester; byte i occupies bits [8i+7:8i].
REQ-007 Port: req_last  input  NUM_REQ  marks the presented byte as the final byte of the packet.
REQ-008 Port: byte_ack  output  NUM_REQ  one-cycle pulse to the granted requester when its byte is taken; the requester then advances to its next byte.
REQ-009 Port: grant  output  NUM_REQ  one-hot owner of the transmitter, held for the whole packet.
REQ-010 Port: tx_data  output  8  byte presented to the transmitter.
REQ-011 Port: tx_start  output  1  one-cycle transmit strobe.
REQ-012 Port: tx_ready  input  1  transmitter idle/ready indication.
REQ-013 Port: busy  output  1  high in every state except IDLE.
REQ-014 Port: overrun  output  1  one-cycle pulse when a packet is truncated at MAX_LEN.

Function
REQ-015 The FSM states SHALL be:
- IDLE
- ARB
- LOAD
- START
- WAIT_LO
- WAIT_HI
- CKSUM (macro only)
- DONE
REQ-016 IDLE SHALL go to ARB when any req bit is high.
REQ-017 ARB SHALL perform round-robin arbitration:
- Search starts at index ptr+1 modulo NUM_REQ.
- The first requester found with req high gets grant.
- ptr is set to that index.
- Next state is LOAD.
REQ-018 LOAD SHALL capture the byte and go to START:
- tx_data <= the granted requester's req_data byte.
- last_flag <= its req_last, OR'd with (byte count == MAX_LEN-1).
- byte_ack pulses for that requester in the same cycle.
REQ-019 START SHALL wait for tx_ready=1, then assert tx_start for exactly one cycle and go to WAIT_LO.
REQ-020 WAIT_LO SHALL wait for tx_ready=0; WAIT_HI SHALL then wait for tx_ready=1.
REQ-021 On exit from WAIT_HI:
- If last_flag is clear: increment the byte count and go to LOAD.
- If last_flag is set: go to CKSUM when the macro is defined, otherwise to DONE.
REQ-022 The byte count SHALL be 5 bits wide and saturate-free; a packet SHALL never exceed MAX_LEN data bytes.
REQ-023 Truncation at MAX_LEN without req_last SHALL pulse overrun once, in the cycle the last byte is loaded.
REQ-024 DONE SHALL, in one cycle:
- clear grant and the byte count;
- return to IDLE.
REQ-025 The FSM SHALL never re-arbitrate without passing through IDLE.
REQ-026 A requester that lowers req mid-packet SHALL be ignored; the packet continues until its last byte.
REQ-027 With simultaneous requests, only one grant SHALL be issued; the others wait for their round-robin turn.
REQ-028 A single continuous requester SHALL be re-granted, since it is the only requester found by the search.
REQ-029 tx_start and byte_ack SHALL never be asserted while grant is zero.

Reset
REQ-030 Reset SHALL be asynchronous on rst_n low, including mid-packet. On reset:
- state = IDLE
- grant = 0
- byte_ack = 0
- tx_start = 0
- tx_data = 8'h00
- busy = 0
- overrun = 0
- ptr = NUM_REQ-1, so requester 0 wins first
- byte count = 0
- checksum = 0
REQ-031 A partially sent packet SHALL NOT be resumed after reset.

Configuration
REQ-032 Macro UART_TX_ARB_CHECKSUM_EN defined:
- A running XOR of every data byte loaded SHALL be kept, cleared in ARB.
- CKSUM SHALL load the XOR into tx_data, then reuse the START/WAIT_LO/WAIT_HI sequence before going to DONE.
- No byte_ack SHALL pulse for the checksum byte.
REQ-033 Macro undefined: no checksum register, no CKSUM state; packets carry data bytes only.

Structure
REQ-034 A shared package uart_pkg SHALL hold:
- the FSM state enumeration;
- default CLK_FREQ and BAUD_RATE constants;
- the MAX_LEN default.
REQ-035 The round-robin selector SHALL be a sub-module, rr_pick:
- inputs: req, ptr;
- outputs: one-hot grant, index;
- purely combinational.

Verification
REQ-036 Bench scenarios:
- Single packet: req[0]=1 with bytes 8'hA5, 8'h3C (last) -> tx_start twice; tx_data A5 then 3C; two byte_ack[0] pulses; grant[0] held until DONE; busy falls after.
- Contention: req=4'b1011 held, 1-byte packets -> grant order 0, 1, 3, 0, 1, 3.
- Overrun: MAX_LEN=4 and req_last never set -> exactly 4 bytes sent; overrun pulses once on the 4th load; grant released.
- Reset mid-packet: rst_n low during WAIT_HI of byte 2 -> all outputs at reset values immediately; the next grant goes to requester 0.
- Checksum (macro defined): bytes 12, 34, 56 -> fourth byte tx_data = 8'h70; byte_ack count = 3.
- Slow ready: tx_ready held low 50 cycles after reset -> no tx_start until tx_ready=1.
